// File: rtl/spi_rx_buffer.sv
// Receive-side byte FIFO behind the SPI slave: synchronizes the asynchronous
// byte-complete flag, stores each received word and hands it out on a read/valid pulse.
module spi_rx_buffer #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] din,
   input  logic              din_done,
   input  logic              rd_en,
   input  logic              clr_ovf,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   count,
   output logic              overflow
);

   localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

   logic              s1_q, s2_q, s3_q;
   logic [ADDR_W-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_W-1:0] rdPtr_q, rdPtr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [DATA_W-1:0] rdData_q, rdData_d;
   logic              rdValid_q, rdValid_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] mem [DEPTH];

   logic wrEvt, rdAcc, wrAcc, drop;

   // A full FIFO still accepts a write when a read frees a slot in the same cycle;
   // an empty FIFO never lets a read fall through to the word being written.
   always_comb begin
      wrEvt     = s2_q & ~s3_q;
      rdAcc     = rd_en & (count_q != '0);
      wrAcc     = wrEvt & ((count_q != FULL_CNT) | rdAcc);
      drop      = wrEvt & ~wrAcc;
      wrPtr_d   = wrPtr_q;
      rdPtr_d   = rdPtr_q;
      count_d   = count_q;
      rdData_d  = rdData_q;
      rdValid_d = rdAcc;
      ovf_d     = ovf_q;
      if (wrAcc) begin
         wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (rdAcc) begin
         rdPtr_d  = rdPtr_q + PTR_ONE;
         rdData_d = mem[rdPtr_q];
      end
      if (wrAcc && !rdAcc) begin
         count_d = count_q + CNT_ONE;
      end else if (rdAcc && !wrAcc) begin
         count_d = count_q - CNT_ONE;
      end
      if (drop) begin
         ovf_d = 1'b1;
      end else if (clr_ovf) begin
         ovf_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         s3_q      <= 1'b0;
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         rdData_q  <= '0;
         rdValid_q <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         s1_q      <= din_done;
         s2_q      <= s1_q;
         s3_q      <= s2_q;
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         count_q   <= count_d;
         rdData_q  <= rdData_d;
         rdValid_q <= rdValid_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (wrAcc) begin
         mem[wrPtr_q] <= din;
      end
   end

   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;
   assign count    = count_q;
   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign overflow = ovf_q;

endmodule
